// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, parser state encoding and ignored-byte lookup.
// Optional build macro PS2_PARITY_CHECK_EN is consumed by ps2_frame_rx.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam logic [7:0]  PS2_BRK       = 8'hF0;
  localparam logic [7:0]  PS2_PAUSE     = 8'hE1;
  localparam int unsigned PS2_FRAME_LEN = 11;

  localparam logic [7:0] PS2_IGNORED [8] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b == PS2_IGNORED[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 bit-level receiver: synchronizers, clock level filter, 11-bit framing, timeout.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity or a low stop bit.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    shift_q, shift_d;
  logic          strobe_q, strobe_d;
  logic          fall;
  logic          data;
  logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  assign data = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  // data is the stop bit at the moment the last strobe is taken
  assign frame_ok = (^{shift_q, par_q}) & data;
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    strobe_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;

    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == '0) begin
        if (!data) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q == 4'(PS2_FRAME_LEN - 1)) begin
        bit_cnt_d = '0;
        strobe_d  = frame_ok;
      end else begin
        if (bit_cnt_q <= 4'd8) shift_d = {data, shift_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
        else par_d = data;
`endif
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = '0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      strobe_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      strobe_q    <= strobe_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign rx_byte     = shift_q;
  assign byte_strobe = strobe_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: make/break/extended parser and 512-bit pressed-key map.
// Build option PS2_PARITY_CHECK_EN (see ps2_frame_rx) enables frame parity/stop checking.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid
);

  logic [7:0]   rx_byte;
  logic         byte_strobe;
  ps2_state_e   state_q, state_d;
  logic [511:0] key_down_q, key_down_d;
  logic [8:0]   last_change_q, last_change_d;
  logic         key_valid_q, key_valid_d;
  logic [8:0]   code;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst),
    .ps2_clk    (PS2_CLK),
    .ps2_data   (PS2_DATA),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe)
  );

  always_comb begin
    state_d       = state_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    key_valid_d   = 1'b0;
    code          = '0;

    if (byte_strobe) begin
      if (rx_byte == PS2_EXT) begin
        if (state_q == IDLE) state_d = EXT;
      end else if (rx_byte == PS2_BRK) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else if (rx_byte == PS2_PAUSE) begin
        state_d = state_q;
      end else if (ps2_is_ignored(rx_byte)) begin
        state_d = IDLE;
      end else if (state_q == IDLE || state_q == EXT) begin
        state_d = IDLE;
        code    = {state_q == EXT, rx_byte};
        // held key: typematic repeat leaves outputs untouched
        if (!key_down_q[code]) begin
          key_down_d[code] = 1'b1;
          last_change_d    = code;
          key_valid_d      = 1'b1;
        end
      end else begin
        state_d          = IDLE;
        code             = {state_q == EXT_BRK, rx_byte};
        key_down_d[code] = 1'b0;
        last_change_d    = code;
        key_valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      key_valid_q   <= key_valid_d;
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign key_valid   = key_valid_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receive-only PS/2 keyboard front end that turns raw PS2_CLK/PS2_DATA traffic into a per-key pressed bitmap, the most recently changed 9-bit key code, and a one-cycle change strobe. It sits directly upstream of the lab06 elevator/LED controller. That controller consumes `key_down[last_change]` qualified by `key_valid` to count right-keypad presses. The block handles PS/2 bit framing, glitch filtering, frame timeout, and make/break/extended scan-code parsing.

## Interface
- FILTER_LEN, 8: consecutive identical synchronized PS2_CLK samples required before the filtered level changes.
- TIMEOUT_CYCLES, 100000: idle clk cycles allowed between falling edges mid-frame before the frame is abandoned. This is 1 ms at 100 MHz.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- PS2_CLK  inout  1  keyboard clock. Never driven; held at high-Z.
- PS2_DATA  inout  1  keyboard data. Never driven; held at high-Z.
- key_down  output  512  bit i is high while key code i is held. Index is {extended, scan_byte}.
- last_change  output  9  code of the last key whose state changed.
- key_valid  output  1  one-cycle pulse when key_down and last_change have just been updated.

## Operation
Receiver path:
- PS2_CLK and PS2_DATA each pass through a 2-FF synchronizer.
- The synchronized PS2_CLK then passes through a FILTER_LEN-deep level filter.
- A 1→0 transition of the filtered clock is a bit strobe; PS2_DATA is sampled on it.
- A frame is 11 bits, LSB first: start (0), 8 data bits, odd parity, stop (1).
- Bit counter 0..10. Reaching 10 completes the frame, and the counter returns to 0.
- Start bit sampled as 1: discard it and keep the counter at 0.
- Mid-frame, if the timeout counter reaches TIMEOUT_CYCLES without a strobe, the bit counter clears and the partial frame is dropped.

Parser FSM (states IDLE, EXT, BRK, EXT_BRK), acting on each accepted byte b:
- 8'hE0: IDLE→EXT.
- 8'hF0: IDLE→BRK, EXT→EXT_BRK.
- Other byte, make (from IDLE or EXT):
  - code = {state==EXT, b}.
  - If key_down[code] is already 1 (typematic repeat), there is no update and no pulse.
  - Otherwise set key_down[code], load last_change=code, pulse key_valid.
  - Return to IDLE.
- Other byte, break (from BRK or EXT_BRK):
  - code = {state==EXT_BRK, b}.
  - Clear key_down[code], load last_change=code, pulse key_valid. This happens even if the bit was already 0.
  - Return to IDLE.
- Ignored bytes 8'h00, AA, EE, FA, FC, FD, FE, FF: no output change; FSM returns to IDLE.
- 8'hE1: ignored; FSM state unchanged.
- A second E0 in EXT, or a second F0 in BRK/EXT_BRK, leaves the state unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - key_down=0, last_change=9'h000, key_valid=0.
  - FSM in IDLE; bit counter and timeout counter at 0.
  - Synchronizer and filter flops at 1 (idle bus level).
- Latency, with cycle N being the cycle the stop-bit strobe is detected:
  - Internal byte strobe in N+1.
  - key_down, last_change, and key_valid visible in N+2.
  - key_valid is high for exactly one cycle.
- Filtered-clock delay from the pin is 2 + FILTER_LEN cycles.
- Pin glitches shorter than FILTER_LEN cycles produce no strobe.
- rst asserted mid-frame or mid-prefix: everything returns to reset values. The next start bit begins a fresh frame.
- Only one byte can complete per strobe, so key_valid can never coincide with a second update.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - A frame is accepted only if data^parity has odd population count and stop==1.
  - Otherwise the byte is dropped, the FSM is unaffected, and the bit counter returns to 0.
- Undefined: parity and stop bits are ignored and every complete frame is accepted.

## Structure
Package ps2_pkg holds:
- Prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- The ignored-byte list.
- The parser state enum {IDLE, EXT, BRK, EXT_BRK}.
- Frame length 11.

Sub-module ps2_frame_rx contains:
- Synchronizers, filter, bit counter, timeout, and parity check.
- Outputs byte[7:0] and byte_strobe.

The top level holds the parser FSM and the 512-bit key_down register.

## Test plan
- Send frame 8'h69, then F0, 69 → first: key_down[9'h069]=1, last_change=9'h069, one key_valid pulse; after the break: key_down[9'h069]=0, second pulse.
- Send E0 75, then E0 F0 75 → key_down[9'h175] sets, then clears; last_change=9'h175 each time; key_down[9'h075] stays 0.
- Send 72 three times (typematic), no break → exactly one key_valid pulse; key_down[9'h072]=1.
- With PS2_PARITY_CHECK_EN, send 7A with wrong parity, then 7A correct → only the second produces a pulse. Without the macro, both are accepted and the second is a suppressed repeat.
- Send 5 bits of a frame, idle 120000 cycles, then a full frame 69 → the partial frame is dropped and 69 decodes correctly.
- Assert rst for 3 cycles during the 6th bit of an F0 frame → all outputs 0, FSM IDLE; a following frame 69 sets key_down[9'h069].
